axi4_to_tl: RTL

- AXI4 subordinate-to-TileLink manager bridge; the reverse of the existing TileLink-to-AXI4 bridge.
- Lets AXI4 initiators (DMA engines, debug masters) reach TileLink-attached memory and peripherals.
- Converts each AXI4 read or write burst into a sequence of single-beat TileLink Get or Put transactions, with one TileLink transaction outstanding at a time.
- Collects the TileLink AccessAck/AccessAckData responses and returns them as AXI4 R beats or a single B response.

---
 rtl/axi_pkg.sv | 54 +++++
 rtl/tl_pkg.sv | 37 +++
 rtl/axi4_to_tl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// +--------------------------------------------------------------------------+
// | Package : axi_pkg                                                         |
// | Brief   : AXI4 channel payload types and encodings used by axi4_to_tl.    |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package axi_pkg;

    localparam logic [1:0] c_BURST_FIXED = 2'd0;
    localparam logic [1:0] c_BURST_INCR  = 2'd1;
    localparam logic [1:0] c_BURST_WRAP  = 2'd2;

    localparam logic [1:0] c_RESP_OKAY   = 2'd0;
    localparam logic [1:0] c_RESP_SLVERR = 2'd2;
    localparam logic [1:0] c_RESP_DECERR = 2'd3;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } aw_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

endpackage

`default_nettype wire

// File: rtl/tl_pkg.sv
// +--------------------------------------------------------------------------+
// | Package : tl_pkg                                                          |
// | Brief   : TileLink A/D channel payload types and opcodes (64-bit data).   |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package tl_pkg;

    localparam logic [2:0] c_OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] c_OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] c_OP_GET         = 3'd4;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [2:0]  size;
        logic [7:0]  source;
        logic [63:0] address;
        logic [7:0]  mask;
        logic [63:0] data;
    } A_chan_bits_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [2:0]  size;
        logic [7:0]  source;
        logic [7:0]  sink;
        logic        denied;
        logic [63:0] data;
        logic        corrupt;
    } D_chan_bits_t;

endpackage

`default_nettype wire

// File: rtl/axi4_to_tl.sv
// +--------------------------------------------------------------------------+
// | Module : axi4_to_tl                                                       |
// | Brief  : AXI4 subordinate to TileLink manager bridge; bursts become       |
// |          single-beat Get/Put transactions, one outstanding at a time.     |
// | Rev    : 1.0  initial release                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module axi4_to_tl #(
    parameter int SOURCE_ID = 0,
    parameter int MAX_LEN   = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                AXI_AW_valid_i,
    output logic                AXI_AW_ready_o,
    input  axi_pkg::aw_chan_t   AXI_AW_bits_i,
    input  logic                AXI_W_valid_i,
    output logic                AXI_W_ready_o,
    input  axi_pkg::w_chan_t    AXI_W_bits_i,
    output logic                AXI_B_valid_o,
    input  logic                AXI_B_ready_i,
    output axi_pkg::b_chan_t    AXI_B_bits_o,
    input  logic                AXI_AR_valid_i,
    output logic                AXI_AR_ready_o,
    input  axi_pkg::ar_chan_t   AXI_AR_bits_i,
    output logic                AXI_R_valid_o,
    input  logic                AXI_R_ready_i,
    output axi_pkg::r_chan_t    AXI_R_bits_o,
    output logic                TL_A_valid_o,
    input  logic                TL_A_ready_i,
    output tl_pkg::A_chan_bits_t TL_A_bits_o,
    input  logic                TL_D_valid_i,
    output logic                TL_D_ready_o,
    input  tl_pkg::D_chan_bits_t TL_D_bits_i
);

    import axi_pkg::*;
    import tl_pkg::*;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_RD_REQ = 4'd1,
        S_RD_RSP = 4'd2,
        S_WR_DAT = 4'd3,
        S_WR_REQ = 4'd4,
        S_WR_RSP = 4'd5,
        S_WR_B   = 4'd6,
        S_ERR_R  = 4'd7,
        S_ERR_B  = 4'd8
    } state_t;

    state_t      r_state;
    logic        r_prio;
    logic [3:0]  r_id;
    logic [63:0] r_addr;
    logic [7:0]  r_len;
    logic [7:0]  r_cnt;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [63:0] r_data;
    logic [7:0]  r_strb;
    logic        r_slverr;
    logic        r_decerr;

    logic        w_idle;
    logic        w_aw_grant;
    logic        w_ar_grant;
    logic        w_aw_bad;
    logic        w_ar_bad;
    logic        w_last;
    logic [63:0] w_step;
    logic [63:0] w_next_addr;
    logic        w_is_get;
    logic        w_unused_d;

    function automatic logic f_bad(input logic [1:0] burst, input logic [2:0] size,
                                   input logic [7:0] len);
        return (burst == c_BURST_WRAP) || (size > 3'd3) || (int'(len) > MAX_LEN);
    endfunction

    // r_prio==0 favours AW when both address channels are valid
    assign w_aw_grant = AXI_AW_valid_i && (!AXI_AR_valid_i || !r_prio);
    assign w_ar_grant = AXI_AR_valid_i && (!AXI_AW_valid_i || r_prio);
    assign w_aw_bad   = f_bad(AXI_AW_bits_i.burst, AXI_AW_bits_i.size, AXI_AW_bits_i.len);
    assign w_ar_bad   = f_bad(AXI_AR_bits_i.burst, AXI_AR_bits_i.size, AXI_AR_bits_i.len);
    assign w_idle     = (r_state == S_IDLE) && !rst_i;
    assign w_last     = (r_cnt == r_len);

    assign w_step      = 64'd1 << r_size;
    assign w_next_addr = (r_burst == c_BURST_FIXED) ? r_addr
                                                    : ((r_addr & ~(w_step - 64'd1)) + w_step);

    assign w_unused_d = ^{TL_D_bits_i.opcode, TL_D_bits_i.param, TL_D_bits_i.size,
                          TL_D_bits_i.source, TL_D_bits_i.sink};

    assign AXI_AW_ready_o = w_idle && w_aw_grant;
    assign AXI_AR_ready_o = w_idle && w_ar_grant;
    assign AXI_W_ready_o  = !rst_i && ((r_state == S_WR_DAT) || (r_state == S_ERR_B));
    assign AXI_B_valid_o  = !rst_i && (r_state == S_WR_B);
    assign AXI_R_valid_o  = !rst_i && (((r_state == S_RD_RSP) && TL_D_valid_i) ||
                                       (r_state == S_ERR_R));
    assign TL_A_valid_o   = !rst_i && ((r_state == S_RD_REQ) || (r_state == S_WR_REQ));
    assign TL_D_ready_o   = !rst_i && (((r_state == S_RD_RSP) && AXI_R_ready_i) ||
                                       (r_state == S_WR_RSP));

    assign w_is_get = (r_state == S_RD_REQ);

    always_comb begin
        TL_A_bits_o         = '0;
        TL_A_bits_o.opcode  = w_is_get ? c_OP_GET :
                              ((r_strb == 8'hff) ? c_OP_PUT_FULL : c_OP_PUT_PARTIAL);
        TL_A_bits_o.param   = 3'd0;
        TL_A_bits_o.size    = 3'd0;
        TL_A_bits_o.source  = 8'(SOURCE_ID);
        TL_A_bits_o.address = r_addr;
        TL_A_bits_o.mask    = w_is_get ? 8'hff : r_strb;
        TL_A_bits_o.data    = w_is_get ? 64'd0 : r_data;
    end

    always_comb begin
        AXI_R_bits_o      = '0;
        AXI_R_bits_o.id   = r_id;
        AXI_R_bits_o.last = w_last;
        if (r_state == S_RD_RSP) begin
            AXI_R_bits_o.data = TL_D_bits_i.data;
            AXI_R_bits_o.resp = TL_D_bits_i.denied  ? c_RESP_DECERR :
                                TL_D_bits_i.corrupt ? c_RESP_SLVERR : c_RESP_OKAY;
        end else begin
            AXI_R_bits_o.resp = c_RESP_SLVERR;
        end
    end

    always_comb begin
        AXI_B_bits_o      = '0;
        AXI_B_bits_o.id   = r_id;
        AXI_B_bits_o.resp = r_decerr ? c_RESP_DECERR :
                            r_slverr ? c_RESP_SLVERR : c_RESP_OKAY;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_prio   <= 1'b0;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_data   <= '0;
            r_strb   <= '0;
            r_slverr <= 1'b0;
            r_decerr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_aw_grant) begin
                        r_id     <= AXI_AW_bits_i.id;
                        r_addr   <= AXI_AW_bits_i.addr;
                        r_len    <= AXI_AW_bits_i.len;
                        r_size   <= AXI_AW_bits_i.size;
                        r_burst  <= AXI_AW_bits_i.burst;
                        r_cnt    <= '0;
                        r_prio   <= ~r_prio;
                        r_decerr <= 1'b0;
                        r_slverr <= w_aw_bad;
                        r_state  <= w_aw_bad ? S_ERR_B : S_WR_DAT;
                    end else if (w_ar_grant) begin
                        r_id     <= AXI_AR_bits_i.id;
                        r_addr   <= AXI_AR_bits_i.addr;
                        r_len    <= AXI_AR_bits_i.len;
                        r_size   <= AXI_AR_bits_i.size;
                        r_burst  <= AXI_AR_bits_i.burst;
                        r_cnt    <= '0;
                        r_prio   <= ~r_prio;
                        r_state  <= w_ar_bad ? S_ERR_R : S_RD_REQ;
                    end
                end
                S_RD_REQ: if (TL_A_ready_i) r_state <= S_RD_RSP;
                S_RD_RSP: begin
                    if (TL_D_valid_i && AXI_R_ready_i) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 8'd1;
                            r_addr  <= w_next_addr;
                            r_state <= S_RD_REQ;
                        end
                    end
                end
                S_WR_DAT: begin
                    if (AXI_W_valid_i) begin
                        r_data  <= AXI_W_bits_i.data;
                        r_strb  <= AXI_W_bits_i.strb;
                        // the beat counter, not W.last, decides where the burst ends
                        if (AXI_W_bits_i.last != w_last) r_slverr <= 1'b1;
                        r_state <= S_WR_REQ;
                    end
                end
                S_WR_REQ: if (TL_A_ready_i) r_state <= S_WR_RSP;
                S_WR_RSP: begin
                    if (TL_D_valid_i) begin
                        if (TL_D_bits_i.denied)  r_decerr <= 1'b1;
                        if (TL_D_bits_i.corrupt) r_slverr <= 1'b1;
                        if (w_last) begin
                            r_state <= S_WR_B;
                        end else begin
                            r_cnt   <= r_cnt + 8'd1;
                            r_addr  <= w_next_addr;
                            r_state <= S_WR_DAT;
                        end
                    end
                end
                S_WR_B: begin
                    if (AXI_B_ready_i) begin
                        r_slverr <= 1'b0;
                        r_decerr <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_ERR_R: begin
                    if (AXI_R_ready_i) begin
                        if (w_last) r_state <= S_IDLE;
                        else        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                S_ERR_B: begin
                    if (AXI_W_valid_i) begin
                        if (w_last) r_state <= S_WR_B;
                        else        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
